// File: rtl/run_length_detector_if.sv
// Bus bundle for run_length_detector: the sample stream with its runtime
// controls, and the registered detection results coming back.
//
// Handshake: valid-only, no back-pressure. A sample on `in` is consumed on
// every rising clk edge where in_valid is 1. The detector is always ready.
// Controls (thresh, mode, overlap) are looked at only on those edges, and
// clr_cnt acts on every edge whether or not a sample is present.
interface run_length_detector_if #(
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) ();
  logic             in_valid;
  logic             in;
  logic [LEN_W-1:0] thresh;
  logic [1:0]       mode;
  logic             overlap;
  logic             clr_cnt;

  logic             out;
  logic             out_bit;
  logic [LEN_W-1:0] run_len;
  logic [CNT_W-1:0] hit_cnt0;
  logic [CNT_W-1:0] hit_cnt1;
  logic             dbg_have_bit;

  modport master (
    output in_valid, in, thresh, mode, overlap, clr_cnt,
    input  out, out_bit, run_len, hit_cnt0, hit_cnt1, dbg_have_bit
  );

  modport slave (
    input  in_valid, in, thresh, mode, overlap, clr_cnt,
    output out, out_bit, run_len, hit_cnt0, hit_cnt1, dbg_have_bit
  );
endinterface

// File: rtl/run_length_detector.sv
// Run-length detector: flags a run of `thresh` identical bits on a serial
// stream, with per-polarity enable, overlapping or one-shot detection and
// saturating per-polarity hit counters. All outputs are registered.
module run_length_detector #(
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input logic                 clk,
  input logic                 reset,
  run_length_detector_if.slave bus
);

  // ST_EMPTY: no bit accepted since reset, so out_bit carries no run yet.
  // ST_RUN:   out_bit/run_len describe the current run.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t           state_q, state_d;
  logic             out_q, out_d;
  logic             bit_q, bit_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic             new_run;
  logic             en;
  logic             hit;
  logic [LEN_W-1:0] len_n;

  // Decode the incoming sample: run continuation, saturating length,
  // polarity enable and the hit event.
  always_comb begin
    new_run = (state_q == ST_EMPTY) || (bus.in != bit_q);

    len_n = len_q;
    if (new_run) begin
      len_n = LEN_ONE;
    end else if (len_q != LEN_MAX) begin
      len_n = len_q + LEN_ONE;
    end

    en = 1'b0;
    if (bus.thresh != '0) begin
      unique case (bus.mode)
        2'b00:   en = 1'b1;
        2'b01:   en = (bus.in == 1'b0);
        2'b10:   en = (bus.in == 1'b1);
        default: en = 1'b0;
      endcase
    end

    // A hit is the step onto thresh. A run stuck at LEN_MAX does not
    // step, so it can never re-trigger an event.
    hit = 1'b0;
    if (en) begin
      if (new_run) begin
        hit = (bus.thresh == LEN_ONE);
      end else begin
        hit = (len_q != LEN_MAX) && (len_n == bus.thresh);
      end
    end
  end

  // Next-state for the run tracker and the registered detection flag.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    bit_d   = bit_q;
    len_d   = len_q;

    if (bus.in_valid) begin
      state_d = ST_RUN;
      bit_d   = bus.in;
      if (bus.overlap) begin
        len_d = len_n;
        out_d = en && (len_n >= bus.thresh);
      end else begin
        // One-shot: restart the count after a hit but keep the polarity,
        // so a further thresh identical bits are needed for the next hit.
        out_d = hit;
        len_d = hit ? '0 : len_n;
      end
    end
  end

  // Hit counters: clear beats a same-cycle event; increments saturate.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;

    if (bus.clr_cnt) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else if (bus.in_valid && hit) begin
      if (bus.in) begin
        if (cnt1_q != CNT_MAX) cnt1_d = cnt1_q + CNT_W'(1);
      end else begin
        if (cnt0_q != CNT_MAX) cnt0_d = cnt0_q + CNT_W'(1);
      end
    end
  end

  // State register; synchronous reset discards any run in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      out_q   <= 1'b0;
      bit_q   <= 1'b0;
      len_q   <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      bit_q   <= bit_d;
      len_q   <= len_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign bus.out          = out_q;
  assign bus.out_bit      = bit_q;
  assign bus.run_len      = len_q;
  assign bus.hit_cnt0     = cnt0_q;
  assign bus.hit_cnt1     = cnt1_q;
  assign bus.dbg_have_bit = (state_q == ST_RUN);

endmodule

// File: tb/tb_run_length_detector.sv
// Bench for run_length_detector. Two instances share one stimulus stream:
// a default-sized one (LEN_W=4, CNT_W=8) and a narrow one (LEN_W=2, CNT_W=2)
// so length and counter saturation are reachable in a few cycles.
module tb_run_length_detector;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_t    = 1'b1;
  logic       in_valid_t = 1'b0;
  logic       in_t       = 1'b0;
  logic [3:0] thresh_t   = 4'd0;
  logic [1:0] mode_t     = 2'b00;
  logic       overlap_t  = 1'b1;
  logic       clr_t      = 1'b0;

  run_length_detector_if #(.LEN_W(4), .CNT_W(8)) bus_m ();
  run_length_detector_if #(.LEN_W(2), .CNT_W(2)) bus_s ();

  assign bus_m.in_valid = in_valid_t;
  assign bus_m.in       = in_t;
  assign bus_m.thresh   = thresh_t;
  assign bus_m.mode     = mode_t;
  assign bus_m.overlap  = overlap_t;
  assign bus_m.clr_cnt  = clr_t;

  assign bus_s.in_valid = in_valid_t;
  assign bus_s.in       = in_t;
  assign bus_s.thresh   = thresh_t[1:0];
  assign bus_s.mode     = mode_t;
  assign bus_s.overlap  = overlap_t;
  assign bus_s.clr_cnt  = clr_t;

  run_length_detector #(.LEN_W(4), .CNT_W(8)) dut_m (
    .clk   (clk),
    .reset (reset_t),
    .bus   (bus_m)
  );

  run_length_detector #(.LEN_W(2), .CNT_W(2)) dut_s (
    .clk   (clk),
    .reset (reset_t),
    .bus   (bus_s)
  );

  // ---------------- reference model ----------------
  // Index 0 = wide instance, 1 = narrow instance.
  int lmax[2] = '{15, 3};
  int cmax[2] = '{255, 3};
  int m_out[2], m_bit[2], m_have[2], m_len[2], m_c0[2], m_c1[2];

  int n_tests = 0;
  int n_fail  = 0;

  // Apply one clock edge's worth of behaviour to the model, using the
  // inputs that the DUTs sample on that edge.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int thr;
      int len_n;
      bit nr;
      bit en;
      bit evt;
      thr = (d == 0) ? int'(thresh_t) : int'(thresh_t[1:0]);
      evt = 1'b0;
      if (reset_t) begin
        m_out[d] = 0; m_bit[d] = 0; m_have[d] = 0;
        m_len[d] = 0; m_c0[d]  = 0; m_c1[d]   = 0;
      end else begin
        if (in_valid_t) begin
          nr    = (m_have[d] == 0) || (int'(in_t) != m_bit[d]);
          len_n = nr ? 1 : ((m_len[d] + 1 > lmax[d]) ? lmax[d] : m_len[d] + 1);
          en    = (thr != 0) && ((mode_t == 2'b00) ||
                                 (mode_t == 2'b01 && in_t == 1'b0) ||
                                 (mode_t == 2'b10 && in_t == 1'b1));
          evt   = en && (nr ? (thr == 1) : (m_len[d] + 1 == thr));
          m_have[d] = 1;
          m_bit[d]  = int'(in_t);
          if (overlap_t) begin
            m_len[d] = len_n;
            m_out[d] = (en && len_n >= thr) ? 1 : 0;
          end else begin
            m_out[d] = evt ? 1 : 0;
            m_len[d] = evt ? 0 : len_n;
          end
        end
        if (clr_t) begin
          m_c0[d] = 0;
          m_c1[d] = 0;
        end else if (evt) begin
          if (in_t) m_c1[d] = (m_c1[d] < cmax[d]) ? m_c1[d] + 1 : cmax[d];
          else      m_c0[d] = (m_c0[d] < cmax[d]) ? m_c0[d] + 1 : cmax[d];
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("m.out",      32'(bus_m.out),      32'(m_out[0]));
    chk("m.out_bit",  32'(bus_m.out_bit),  32'(m_bit[0]));
    chk("m.run_len",  32'(bus_m.run_len),  32'(m_len[0]));
    chk("m.hit_cnt0", 32'(bus_m.hit_cnt0), 32'(m_c0[0]));
    chk("m.hit_cnt1", 32'(bus_m.hit_cnt1), 32'(m_c1[0]));
    chk("s.out",      32'(bus_s.out),      32'(m_out[1]));
    chk("s.out_bit",  32'(bus_s.out_bit),  32'(m_bit[1]));
    chk("s.run_len",  32'(bus_s.run_len),  32'(m_len[1]));
    chk("s.hit_cnt0", 32'(bus_s.hit_cnt0), 32'(m_c0[1]));
    chk("s.hit_cnt1", 32'(bus_s.hit_cnt1), 32'(m_c1[1]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic b, input logic c);
    in_valid_t = v;
    in_t       = b;
    clr_t      = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset_t = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    reset_t = 1'b0;
  endtask

  task automatic config_set(input logic [3:0] t, input logic [1:0] m, input logic ov);
    thresh_t  = t;
    mode_t    = m;
    overlap_t = ov;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [9:0] legacy;
    logic [5:0] gaps;
    logic [4:0] pol;
    legacy = 10'b0_1111_00000; // bit i is sample i
    gaps   = 6'b100101;
    pol    = 5'b11000;

    do_reset();
    chk("reset out",  32'(bus_m.out),      32'd0);
    chk("reset hit0", 32'(bus_m.hit_cnt0), 32'd0);

    // Legacy fixed-detector behaviour
    config_set(4'd4, 2'b00, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, legacy[i], 1'b0);
    chk("legacy hit0", 32'(bus_m.hit_cnt0), 32'd1);
    chk("legacy hit1", 32'(bus_m.hit_cnt1), 32'd1);

    // One-shot detection on seven ones
    do_reset();
    config_set(4'd3, 2'b00, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0);
    chk("nonov run_len", 32'(bus_m.run_len),  32'd1);
    chk("nonov hit1",    32'(bus_m.hit_cnt1), 32'd2);

    // Ones-only polarity mask
    do_reset();
    config_set(4'd2, 2'b10, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, pol[i], 1'b0);
    chk("mask out",  32'(bus_m.out),      32'd1);
    chk("mask hit0", 32'(bus_m.hit_cnt0), 32'd0);
    chk("mask hit1", 32'(bus_m.hit_cnt1), 32'd1);

    // Valid gaps hold state
    do_reset();
    config_set(4'd3, 2'b00, 1'b1);
    for (int i = 0; i < 6; i++) step(gaps[i], 1'b1, 1'b0);
    chk("gaps run_len", 32'(bus_m.run_len), 32'd3);

    // Length saturation (narrow instance sticks at 3)
    do_reset();
    config_set(4'd3, 2'b00, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
    chk("sat run_len", 32'(bus_s.run_len),  32'd3);
    chk("sat out",     32'(bus_s.out),      32'd1);
    chk("sat hit0",    32'(bus_s.hit_cnt0), 32'd1);

    // Counter saturation: four single-bit runs of zeros
    do_reset();
    config_set(4'd1, 2'b00, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'(i % 2), 1'b0);
    chk("cntsat s.hit0", 32'(bus_s.hit_cnt0), 32'd3);
    chk("cntsat m.hit0", 32'(bus_m.hit_cnt0), 32'd4);

    // Clear wins over a same-cycle event
    step(1'b1, 1'b0, 1'b1);
    chk("clr m.hit0", 32'(bus_m.hit_cnt0), 32'd0);
    chk("clr m.hit1", 32'(bus_m.hit_cnt1), 32'd0);

    // Clear while no sample is accepted
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);

    // Lowered threshold mid-run: out asserts without counting an event
    do_reset();
    config_set(4'd5, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    thresh_t = 4'd2;
    step(1'b1, 1'b1, 1'b0);
    chk("lower out",  32'(bus_m.out),      32'd1);
    chk("lower hit1", 32'(bus_m.hit_cnt1), 32'd0);

    // Reset mid-run, then the next bit starts a fresh run
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    chk("post-reset run_len", 32'(bus_m.run_len), 32'd1);

    // Random phase
    for (int i = 0; i < 600; i++) begin
      logic v, b, c;
      if (i % 23 == 0) thresh_t  = 4'($urandom_range(0, 6));
      if (i % 31 == 0) mode_t    = 2'($urandom_range(0, 3));
      if (i % 17 == 0) overlap_t = 1'($urandom_range(0, 1));
      reset_t = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 9) < 7) ? in_t : ~in_t;
      c = ($urandom_range(0, 39) == 0);
      step(v, b, c);
    end
    reset_t = 1'b0;

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
